// File: rtl/rv_decode_stage.sv
// rv_decode_stage: pipelined multi-lane RV32 instruction decode stage.
// Decodes LANES instructions per bundle into opcode, register indices, funct fields,
// shamt, a sign-extended immediate and an illegal flag. A registered output stage plus
// a one-entry skid buffer sustains full throughput under backpressure.
// Optional build macro: DECODE_RVM_EN -- when defined, OP with funct7=0000001 (RV32M)
// decodes as legal; otherwise it is flagged illegal.
module rv_decode_stage #(
    parameter int unsigned LANES = 2,
    parameter int unsigned SEQ_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_vld,
    input  logic [32*LANES-1:0]   in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_lane_vld,
    output logic [7*LANES-1:0]    out_opcode,
    output logic [5*LANES-1:0]    out_rd,
    output logic [5*LANES-1:0]    out_rs1,
    output logic [5*LANES-1:0]    out_rs2,
    output logic [5*LANES-1:0]    out_shamt,
    output logic [3*LANES-1:0]    out_funct3,
    output logic [7*LANES-1:0]    out_funct7,
    output logic [32*LANES-1:0]   out_imm,
    output logic [LANES-1:0]      out_illegal,
    output logic [SEQ_W-1:0]      out_seq
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mul  = 7'b0000001;

    // Decoded fields of a single lane.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
    } lane_t;

    // One full decoded bundle, as held in the output register or the skid.
    typedef struct packed {
        logic [LANES-1:0]    lane_vld;
        logic [7*LANES-1:0]  opcode;
        logic [5*LANES-1:0]  rd;
        logic [5*LANES-1:0]  rs1;
        logic [5*LANES-1:0]  rs2;
        logic [5*LANES-1:0]  shamt;
        logic [3*LANES-1:0]  funct3;
        logic [7*LANES-1:0]  funct7;
        logic [32*LANES-1:0] imm;
        logic [LANES-1:0]    illegal;
        logic [SEQ_W-1:0]    seq;
    } bundle_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} occ_e;

    occ_e             state_q, state_d;
    bundle_t          out_q, out_d;
    bundle_t          skid_q, skid_d;
    bundle_t          dec;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;
    logic             xfer;

    // Decode one instruction word; caller zeroes invalid lanes.
    function automatic lane_t decode_lane(input logic [31:0] ins);
        lane_t      d;
        logic [2:0] f3;
        logic [6:0] f7;
        d        = '0;
        f3       = ins[14:12];
        f7       = ins[31:25];
        d.opcode = ins[6:0];
        d.rd     = ins[11:7];
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.funct3 = f3;
        d.funct7 = f7;
        case (ins[6:0])
            OpLui, OpAuipc: begin
                d.imm = {ins[31:12], 12'b0};
            end
            OpJal: begin
                d.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OpJalr: begin
                d.imm     = {{20{ins[31]}}, ins[31:20]};
                d.illegal = (f3 != 3'b000);
            end
            OpBranch: begin
                d.imm     = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                d.illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OpLoad: begin
                d.imm     = {{20{ins[31]}}, ins[31:20]};
                d.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OpStore: begin
                d.imm     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                d.illegal = (f3 > 3'b010);
            end
            OpImm: begin
                d.imm     = {{20{ins[31]}}, ins[31:20]};
                // Shift-immediates reuse funct7 as an encoding qualifier.
                d.illegal = ((f3 == 3'b001) && (f7 != F7Base)) ||
                            ((f3 == 3'b101) && (f7 != F7Base) && (f7 != F7Alt));
            end
            OpFence, OpSystem: begin
                d.imm = {{20{ins[31]}}, ins[31:20]};
            end
            OpReg: begin
                if (f7 == F7Base) begin
                    d.illegal = 1'b0;
                end else if (f7 == F7Alt) begin
                    // Only SUB and SRA exist in the alternate encoding.
                    d.illegal = !((f3 == 3'b000) || (f3 == 3'b101));
`ifdef DECODE_RVM_EN
                end else if (f7 == F7Mul) begin
                    d.illegal = 1'b0;
`else
                end else if (f7 == F7Mul) begin
                    d.illegal = 1'b1;
`endif
                end else begin
                    d.illegal = 1'b1;
                end
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        if (ins[1:0] != 2'b11) begin
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    // Combinational decode of the incoming bundle, tagged with the current sequence value.
    always_comb begin
        lane_t l;
        dec          = '0;
        dec.lane_vld = in_lane_vld;
        dec.seq      = seq_q;
        for (int i = 0; i < LANES; i++) begin
            l = '0;
            if (in_lane_vld[i]) begin
                l = decode_lane(in_instr[32*i +: 32]);
            end
            dec.opcode[7*i +: 7]  = l.opcode;
            dec.rd[5*i +: 5]      = l.rd;
            dec.rs1[5*i +: 5]     = l.rs1;
            dec.rs2[5*i +: 5]     = l.rs2;
            dec.shamt[5*i +: 5]   = l.rs2;
            dec.funct3[3*i +: 3]  = l.funct3;
            dec.funct7[7*i +: 7]  = l.funct7;
            dec.imm[32*i +: 32]   = l.imm;
            dec.illegal[i]        = l.illegal;
        end
    end

    assign accept = in_valid && in_ready_q;
    assign xfer   = out_valid_q && out_ready;

    // Occupancy FSM: route decoded bundles into the output register or skid.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        seq_d   = seq_q;
        if (accept) begin
            seq_d = seq_q + SEQ_W'(1);
        end
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    out_d   = dec;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && xfer) begin
                    out_d = dec;
                end else if (accept) begin
                    skid_d  = dec;
                    state_d = StFull;
                end else if (xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (xfer) begin
                    out_d   = skid_q;
                    state_d = StOne;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
        in_ready_d  = (state_d != StFull);
        out_valid_d = (state_d != StEmpty);
    end

    // State, handshake and data registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            out_q       <= '0;
            skid_q      <= '0;
            seq_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            seq_q       <= seq_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_lane_vld = out_q.lane_vld;
    assign out_opcode   = out_q.opcode;
    assign out_rd       = out_q.rd;
    assign out_rs1      = out_q.rs1;
    assign out_rs2      = out_q.rs2;
    assign out_shamt    = out_q.shamt;
    assign out_funct3   = out_q.funct3;
    assign out_funct7   = out_q.funct7;
    assign out_imm      = out_q.imm;
    assign out_illegal  = out_q.illegal;
    assign out_seq      = out_q.seq;

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Parametrised, pipelined multi-lane RV32 instruction decode stage for the dual-issue front end.
- Decodes LANES instructions per bundle into fields: opcode, sign-extended 32-bit immediate, rs1/rs2/rd, funct3/funct7, shamt and an illegal flag.
- Sits between fetch and issue, with valid/ready handshakes on both sides.
- Output register plus one-entry skid buffer, so full throughput is sustained under backpressure.

Parameters:
- LANES, 2, instructions per bundle (1..4).
- SEQ_W, 8, width of the bundle sequence tag.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, fetch bundle valid.
- in_ready, output, 1, stage can accept a bundle.
- in_lane_vld, input, LANES, per-lane instruction valid mask.
- in_instr, input, 32*LANES, instructions; lane i in bits [32i+31:32i].
- out_valid, output, 1, decoded bundle valid.
- out_ready, input, 1, issue accepts the bundle.
- out_lane_vld, output, LANES, registered copy of the lane mask.
- out_opcode, output, 7*LANES, instr[6:0].
- out_rd, output, 5*LANES, instr[11:7].
- out_rs1, output, 5*LANES, instr[19:15].
- out_rs2, output, 5*LANES, instr[24:20].
- out_shamt, output, 5*LANES, instr[24:20].
- out_funct3, output, 3*LANES, instr[14:12].
- out_funct7, output, 7*LANES, instr[31:25].
- out_imm, output, 32*LANES, sign-extended immediate.
- out_illegal, output, LANES, lane instruction is illegal.
- out_seq, output, SEQ_W, bundle sequence tag.

Behaviour:
- Reset: all outputs 0 (out_valid=0, in_ready=1 from the first cycle after reset release); skid empty; sequence counter 0. Reset asserted mid-operation drops all in-flight bundles immediately.
- Accept: a bundle is taken when in_valid && in_ready.
- Sequence tag: each accepted bundle gets the tag counter value, then the counter increments, wrapping 2^SEQ_W-1 -> 0.
- Output transfer: a bundle leaves when out_valid && out_ready.
- Latency: 1 cycle from accept to out_valid when the output register is empty or draining.
- State machine, by occupancy:
  - EMPTY: accept -> ONE.
  - ONE: accept and output transfer in the same cycle -> ONE (new bundle in the output register). Accept with no transfer -> FULL (new bundle in the skid). Transfer with no accept -> EMPTY.
  - FULL: in_ready=0. Output transfer -> ONE, skid contents move to the output register.
- in_ready is registered and equals !FULL.
- Ordering: no bundle is dropped, duplicated or reordered.
- Output stability: while out_valid && !out_ready, all out_* are stable.
- Immediate selection by opcode:
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): sext{instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - I-type (1100111, 0000011, 0010011, 0001111, 1110011): sext instr[31:20].
  - B-type (1100011): sext{instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - S-type (0100011): sext{instr[31:25], instr[11:7]}.
  - R-type (0110011) and unknown opcodes: 0.
- Illegal = lane valid AND any of:
  - instr[1:0] != 11.
  - opcode not in the set above.
  - JALR funct3 != 000.
  - BRANCH funct3 in {010, 011}.
  - LOAD funct3 in {011, 110, 111}.
  - STORE funct3 > 010.
  - OP-IMM with funct3=001 and funct7 != 0000000.
  - OP-IMM with funct3=101 and funct7 not in {0000000, 0100000}.
  - OP with funct7=0100000 and funct3 not in {000, 101}.
  - OP with funct7 not in {0000000, 0100000}, except as allowed by the optional feature.
- Invalid lanes: fields are zero and illegal=0.
- Decode is combinational on input; the result is captured in the output register or skid.

Optional Feature:
- Macro: DECODE_RVM_EN.
- Defined: OP with funct7=0000001 (any funct3, RV32M) is legal.
- Undefined: OP with funct7=0000001 is flagged illegal.
- No other behaviour differs.

Test Plan:
- LANES=2, out_ready=1. Lane0=0x000010B7, lane1=0x00108093. Next cycle: lane0 opcode=0110111, rd=1, imm=0x00001000. Lane1 opcode=0010011, rd=1, rs1=1, imm=0x00000001. Both illegal=0, out_seq=0.
- Lane0=0xFE108EE3 (beq x1,x1,-4), lane1 invalid. Lane0 imm=0xFFFFFFFC, rs1=1, rs2=1, funct3=000. Lane1 all fields 0, illegal=0.
- Lane0=0xFFFFFFFF -> illegal=1. Lane0=0x022081B3 -> illegal=0 with DECODE_RVM_EN defined, 1 without; rd=3, rs1=1, rs2=2, funct7=0000001 in both builds.
- out_ready=0; present bundles A, B, C back-to-back. A and B accepted; in_ready=0 from the cycle after B is accepted; C held. Raise out_ready: outputs A, B, C in order with seq 0, 1, 2, one per cycle.
- SEQ_W=2; send 5 bundles. out_seq = 0, 1, 2, 3, 0.
- Assert rst_n=0 with FULL occupancy. Outputs zero asynchronously. After release: in_ready=1, first new bundle has out_seq=0.
